// File: rtl/playback_streamer.sv
// Plays one output-buffer window to both codec DAC sinks, sample by sample.
// First valid 2 cycles after go_in. A channel's data is held until that channel accepts it.
module playback_streamer #(
  parameter int WINDOW_LEN  = 1024,
  parameter int NUM_WINDOWS = 8,
  parameter int ADDR_W      = 13
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           go_in,
  input  logic [$clog2(NUM_WINDOWS)-1:0] window_start,
  output logic [ADDR_W-1:0]              out_buf_addr,
  input  logic [15:0]                    out_buf_q,
  output logic [15:0]                    left_out_data,
  output logic                           left_out_valid,
  input  logic                           left_out_ready,
  output logic [15:0]                    right_out_data,
  output logic                           right_out_valid,
  input  logic                           right_out_ready,
  output logic                           busy,
  output logic                           done_out,
  output logic                           overrun
);

  localparam int IDX_W = $clog2(WINDOW_LEN);
  localparam int WIN_W = $clog2(NUM_WINDOWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, CAPTURE, PRESENT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base;
  logic [IDX_W-1:0]   idx;
  logic               pend;
  logic [WIN_W-1:0]   pend_win;
  logic               left_acc;
  logic               right_acc;

  logic               left_hs;
  logic               right_hs;
  logic               left_done;
  logic               right_done;
  logic [ADDR_W-1:0]  start_base;

  assign left_hs    = left_out_valid && left_out_ready;
  assign right_hs   = right_out_valid && right_out_ready;
  assign left_done  = left_acc || left_hs;
  assign right_done = right_acc || right_hs;
  // A queued start takes priority over a fresh go_in arriving in the same IDLE cycle.
  assign start_base = ADDR_W'(pend ? pend_win : window_start) << IDX_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      base            <= '0;
      idx             <= '0;
      pend            <= 1'b0;
      pend_win        <= '0;
      left_acc        <= 1'b0;
      right_acc       <= 1'b0;
      out_buf_addr    <= '0;
      left_out_data   <= '0;
      right_out_data  <= '0;
      left_out_valid  <= 1'b0;
      right_out_valid <= 1'b0;
      busy            <= 1'b0;
      done_out        <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (state != IDLE && go_in) begin
        pend     <= 1'b1;
        pend_win <= window_start;
        if (pend) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pend || go_in) begin
            base         <= start_base;
            out_buf_addr <= start_base;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= ADDR;
            pend         <= pend && go_in;
            if (pend && go_in) pend_win <= window_start;
          end
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          left_out_data   <= out_buf_q;
          right_out_data  <= out_buf_q;
          left_out_valid  <= 1'b1;
          right_out_valid <= 1'b1;
          left_acc        <= 1'b0;
          right_acc       <= 1'b0;
          state           <= PRESENT;
        end
        PRESENT: begin
          if (left_hs) begin
            left_out_valid <= 1'b0;
            left_acc       <= 1'b1;
          end
          if (right_hs) begin
            right_out_valid <= 1'b0;
            right_acc       <= 1'b1;
          end
          // Final sample finishes on the accepting edge; earlier samples advance one edge later.
          if (left_done && right_done && idx == LAST_IDX) begin
            done_out <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (left_acc && right_acc) begin
            idx          <= idx + IDX_W'(1);
            out_buf_addr <= base + ADDR_W'(idx) + ADDR_W'(1);
            state        <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playback_streamer.sv
// Randomized bench for playback_streamer with a transaction-level window/pending model.
module tb_playback_streamer;
  localparam int LEN = 4;
  localparam int NW  = 8;
  localparam int AW  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go_in = 1'b0;
  logic [2:0]  window_start = '0;
  logic [AW-1:0] out_buf_addr;
  logic [15:0] out_buf_q = '0;
  logic [15:0] left_out_data, right_out_data;
  logic        left_out_valid, right_out_valid;
  logic        left_out_ready = 1'b0, right_out_ready = 1'b0;
  logic        busy, done_out, overrun;

  playback_streamer #(.WINDOW_LEN(LEN), .NUM_WINDOWS(NW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .go_in(go_in), .window_start(window_start),
    .out_buf_addr(out_buf_addr), .out_buf_q(out_buf_q),
    .left_out_data(left_out_data), .left_out_valid(left_out_valid), .left_out_ready(left_out_ready),
    .right_out_data(right_out_data), .right_out_valid(right_out_valid), .right_out_ready(right_out_ready),
    .busy(busy), .done_out(done_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:NW*LEN-1];
  always @(posedge clk) out_buf_q <= mem[out_buf_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected sample stream per channel plus the single-entry start queue.
  logic [15:0] exp_l[$], exp_r[$];
  int   l_times[$];
  int   cyc = 0;
  int   l_cnt = 0, r_cnt = 0;
  int   dones_seen = 0, dones_exp = 0;
  bit   model_busy = 0, pending_m = 0, overrun_m = 0;
  int   pend_w = 0;
  int   ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: begin left_out_ready = 1'b1; right_out_ready = 1'b1; end
      1: begin left_out_ready = 1'b1; right_out_ready = (cyc % 7 == 0); end
      default: begin
        left_out_ready  = ($urandom_range(0, 3) != 0);
        right_out_ready = ($urandom_range(0, 2) == 0);
      end
    endcase
  end

  task automatic push_window(input int w);
    for (int i = 0; i < LEN; i++) begin
      exp_l.push_back(mem[w * LEN + i]);
      exp_r.push_back(mem[w * LEN + i]);
    end
    dones_exp++;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (left_out_valid && left_out_ready) begin
        if (exp_l.size() == 0) check("left_extra_sample", 1, 0);
        else begin
          check("left_not_ahead_of_right", (l_cnt <= r_cnt), 1);
          check("left_data", left_out_data, exp_l.pop_front());
          l_times.push_back(cyc);
          l_cnt++;
        end
      end
      if (right_out_valid && right_out_ready) begin
        if (exp_r.size() == 0) check("right_extra_sample", 1, 0);
        else begin
          check("right_not_ahead_of_left", (r_cnt <= l_cnt), 1);
          check("right_data", right_out_data, exp_r.pop_front());
          r_cnt++;
        end
      end
      if (done_out) begin
        dones_seen++;
        check("done_with_window_drained", exp_l.size() + exp_r.size(), 0);
        if (pending_m) begin
          push_window(pend_w);
          pending_m = 0;
        end else model_busy = 0;
      end
    end
  end

  task automatic start(input int w);
    @(posedge clk); #1;
    go_in = 1'b1;
    window_start = 3'(w);
    if (!model_busy) begin
      push_window(w);
      model_busy = 1;
    end else begin
      if (pending_m) overrun_m = 1;
      pending_m = 1;
      pend_w = w;
    end
    @(posedge clk); #1;
    go_in = 1'b0;
  endtask

  task automatic start_mid(input int w);
    int t = 0;
    while (!(exp_l.size() > 0 && exp_r.size() > 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("timeout_mid_window", 1, 0);
    start(w);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (model_busy && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) check({tag, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_count"}, dones_seen, dones_exp);
  endtask

  initial begin
    for (int a = 0; a < NW * LEN; a++) mem[a] = 16'((a << 8) | $urandom_range(0, 255));
    mem[8] = 16'h1111; mem[9] = 16'h2222; mem[10] = 16'h3333; mem[11] = 16'h4444;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", out_buf_addr, 0);
    check("rst_ldata", left_out_data, 0);
    check("rst_rdata", right_out_data, 0);
    check("rst_lvalid", left_out_valid, 0);
    check("rst_rvalid", right_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_out, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Basic window with full ready: latency and 4-cycle sample spacing.
    ready_mode = 0;
    l_times.delete();
    start(2);
    check("basic_busy", busy, 1);
    check("basic_addr", out_buf_addr, 2 * LEN);
    @(posedge clk); #1;
    check("basic_valid_not_yet", left_out_valid, 0);
    @(posedge clk); #1;
    check("basic_lvalid_k2", left_out_valid, 1);
    check("basic_rvalid_k2", right_out_valid, 1);
    check("basic_first_sample", left_out_data, 16'h1111);
    wait_idle("basic");
    check("basic_sample_count", l_times.size(), LEN);
    for (int i = 1; i < LEN && i < l_times.size(); i++)
      check("basic_spacing", l_times[i] - l_times[i-1], 4);

    // Skewed readies.
    ready_mode = 1;
    start(4);
    wait_idle("skew");

    // Back-to-back: second window queued mid-playback.
    ready_mode = 1;
    start(0);
    start_mid(1);
    wait_idle("b2b");
    check("b2b_overrun", overrun, 0);

    // Overrun: three starts during one window, only the last survives.
    start(0);
    start_mid(3);
    start_mid(5);
    start_mid(6);
    wait_idle("ovr");
    check("ovr_flag", overrun, 1);
    check("ovr_model_flag", overrun, overrun_m);

    // Last window ends at the top address without wrapping.
    ready_mode = 0;
    start(NW - 1);
    wait_idle("wrap");
    check("wrap_last_addr", out_buf_addr, NW * LEN - 1);

    // Randomized windows and readies.
    ready_mode = 2;
    for (int it = 0; it < 8; it++) begin
      start($urandom_range(0, NW - 1));
      if ($urandom_range(0, 1) == 1) start_mid($urandom_range(0, NW - 1));
      wait_idle("rand");
      check("rand_overrun", overrun, overrun_m);
    end

    // Reset mid-window, then replay.
    begin
      int t = 0;
      start(2);
      start_mid(5);
      while (!left_out_valid && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) check("timeout_rst_valid", 1, 0);
      #1 reset = 1'b1;
      #1;
      check("arst_addr", out_buf_addr, 0);
      check("arst_lvalid", left_out_valid, 0);
      check("arst_rvalid", right_out_valid, 0);
      check("arst_ldata", left_out_data, 0);
      check("arst_busy", busy, 0);
      check("arst_overrun", overrun, 0);
      exp_l.delete(); exp_r.delete();
      l_cnt = 0; r_cnt = 0;
      pending_m = 0; model_busy = 0; overrun_m = 0;
      dones_exp = dones_seen;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("arst_no_done", dones_seen, dones_exp);
      check("arst_pending_dropped", busy, 0);
      start(2);
      wait_idle("replay");
      check("replay_overrun", overrun, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
